// File: rtl/adder_nios_cpu_debug_cmd_sched_if.sv
// Signal bundle between the debug-action sources, the scheduler and the shared OCI command port.
// The scheduler takes the slave side; the bench or the surrounding logic takes the master side.
interface adder_nios_cpu_debug_cmd_sched_if #(
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned DATA_W  = 38,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_SRC-1:0] act_pulse;
  logic [DATA_W-1:0]  jdo;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ID_W-1:0]    cmd_src;
  logic [DATA_W-1:0]  cmd_data;
  logic               cmd_done;
  logic               cmd_err;
  logic               done_pulse;
  logic [ID_W-1:0]    done_src;
  logic               done_err;
  logic               busy;
  logic [NUM_SRC-1:0] overrun;
  logic               ovr_clr;

  modport slave (
    input  act_pulse, jdo, cmd_ready, cmd_done, cmd_err, ovr_clr,
    output cmd_valid, cmd_src, cmd_data, done_pulse, done_src, done_err, busy, overrun
  );

  modport master (
    output act_pulse, jdo, cmd_ready, cmd_done, cmd_err, ovr_clr,
    input  cmd_valid, cmd_src, cmd_data, done_pulse, done_src, done_err, busy, overrun
  );
endinterface

// File: rtl/adder_nios_cpu_debug_cmd_sched.sv
// Sysclk-side scheduler: captures JTAG debug action strobes, keeps one pending command per source
// and issues them one at a time, round-robin, to the shared OCI command port.
module adder_nios_cpu_debug_cmd_sched #(
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned DATA_W  = 38,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  adder_nios_cpu_debug_cmd_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

  state_t              state, state_next;
  logic [NUM_SRC-1:0]  pending, pending_kept, pending_next;
  logic [NUM_SRC-1:0]  overrun_q, overrun_next;
  logic [DATA_W-1:0]   slot [NUM_SRC];
  logic [ID_W-1:0]     rr_ptr, grant, cmd_src_q, done_src_q;
  logic [DATA_W-1:0]   cmd_data_q;
  logic [7:0]          timer;
  logic                done_err_q, retire_err, grant_vld, issue_now;
  logic [NUM_SRC-1:0]  grant_oh, rot;
  logic [2*NUM_SRC-1:0] rot_full;
  logic [ID_W:0]       sum;

  // Rotate pending so that bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin
    rot_full  = {pending, pending} >> rr_ptr;
    rot       = rot_full[NUM_SRC-1:0];
    grant     = '0;
    grant_vld = 1'b0;
    sum       = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!grant_vld && rot[k]) begin
        grant_vld = 1'b1;
        sum       = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_SRC)) sum = sum - (ID_W+1)'(NUM_SRC);
        grant     = sum[ID_W-1:0];
      end
    end
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      grant_oh[i] = grant_vld && (grant == ID_W'(i));
    end
  end

  always_comb begin
    state_next = state;
    retire_err = 1'b0;
    case (state)
      IDLE:   if (grant_vld) state_next = ISSUE;
      ISSUE:  if (bus.cmd_ready) state_next = WAIT;
      WAIT: begin
        if (bus.cmd_done) begin
          state_next = RETIRE;
          retire_err = bus.cmd_err;
        end else if (timer == 8'(TIMEOUT)) begin
          state_next = RETIRE;
          retire_err = 1'b1;
        end
      end
      RETIRE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Overrun is judged after the granted bit is consumed, so a re-strobe of the source just
  // being issued counts as a fresh entry.
  always_comb begin
    issue_now    = (state == IDLE) && grant_vld;
    pending_kept = issue_now ? (pending & ~grant_oh) : pending;
    pending_next = pending_kept | bus.act_pulse;
    overrun_next = (bus.ovr_clr ? '0 : overrun_q) | (bus.act_pulse & pending_kept);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      overrun_q  <= '0;
      rr_ptr     <= '0;
      timer      <= '0;
      cmd_src_q  <= '0;
      cmd_data_q <= '0;
      done_src_q <= '0;
      done_err_q <= 1'b0;
    end else begin
      pending   <= pending_next;
      overrun_q <= overrun_next;
      if (issue_now) begin
        cmd_src_q  <= grant;
        cmd_data_q <= slot[grant];
        rr_ptr     <= (grant == ID_W'(NUM_SRC-1)) ? '0 : grant + ID_W'(1);
      end
      if (state == ISSUE && bus.cmd_ready) timer <= '0;
      else if (state == WAIT)              timer <= timer + 8'd1;
      if (state == WAIT && state_next == RETIRE) begin
        done_src_q <= cmd_src_q;
        done_err_q <= retire_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.act_pulse[i]) slot[i] <= bus.jdo;
    end
  end

  assign bus.cmd_valid  = (state == ISSUE);
  assign bus.cmd_src    = cmd_src_q;
  assign bus.cmd_data   = cmd_data_q;
  assign bus.done_pulse = (state == RETIRE);
  assign bus.done_src   = done_src_q;
  assign bus.done_err   = done_err_q;
  assign bus.busy       = (state != IDLE) || (|pending);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_adder_nios_cpu_debug_cmd_sched.sv
// Bench for the debug command scheduler: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_adder_nios_cpu_debug_cmd_sched;
  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned DATA_W  = 38;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_nios_cpu_debug_cmd_sched_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  adder_nios_cpu_debug_cmd_sched #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  act;
    logic [37:0] jdo;
    logic        rdy, dn, er, oc;
    logic        valid;
    logic [2:0]  src;
    logic [37:0] data;
    logic        dp;
    logic [2:0]  dsrc;
    logic        derr, busy;
    logic [5:0]  ovr;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] a, input logic [37:0] j, input logic r, d, e, o,
                              input logic v, input logic [2:0] s, input logic [37:0] dt,
                              input logic p, input logic [2:0] ds, input logic de, b,
                              input logic [5:0] ov);
    vec_t t;
    t.act = a; t.jdo = j; t.rdy = r; t.dn = d; t.er = e; t.oc = o;
    t.valid = v; t.src = s; t.data = dt; t.dp = p; t.dsrc = ds; t.derr = de; t.busy = b; t.ovr = ov;
    return t;
  endfunction

  task automatic drive_idle();
    bus.act_pulse = '0; bus.jdo = '0; bus.cmd_ready = 1'b0;
    bus.cmd_done = 1'b0; bus.cmd_err = 1'b0; bus.ovr_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.cmd_valid), 0);
    chk({tag, "_src"},   64'(bus.cmd_src), 0);
    chk({tag, "_data"},  64'(bus.cmd_data), 0);
    chk({tag, "_dp"},    64'(bus.done_pulse), 0);
    chk({tag, "_dsrc"},  64'(bus.done_src), 0);
    chk({tag, "_derr"},  64'(bus.done_err), 0);
    chk({tag, "_busy"},  64'(bus.busy), 0);
    chk({tag, "_ovr"},   64'(bus.overrun), 0);
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!bus.cmd_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 64'(bus.cmd_valid), 1);
  endtask

  // Handshake, complete, and check the retire; leaves the bench one cycle after the retire.
  task automatic finish_cmd(input logic e, input int unsigned exp_src);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    bus.cmd_done = 1'b1;
    bus.cmd_err = e;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    bus.cmd_err = 1'b0;
    chk("ret_pulse", 64'(bus.done_pulse), 1);
    chk("ret_src", 64'(bus.done_src), 64'(exp_src));
    chk("ret_err", 64'(bus.done_err), 64'(e));
    @(negedge clk);
  endtask

  // Reference model: pending set, slots, rotating pointer and the lifetime of the in-flight command.
  logic [5:0]  m_pend, m_ovr;
  logic [37:0] m_slot [6];
  logic [37:0] m_data;
  int          m_ptr, m_src, m_dsrc, m_wait;
  logic        m_derr, m_offering, m_waiting, m_retiring;

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_data = '0; m_ptr = 0; m_src = 0; m_dsrc = 0; m_wait = 0;
    m_derr = 1'b0; m_offering = 1'b0; m_waiting = 1'b0; m_retiring = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] a, input logic [37:0] j, input logic rdy, dn, er, oc);
    logic [5:0] keep;
    keep = m_pend;
    if (m_retiring) begin
      m_retiring = 1'b0;
    end else if (m_waiting) begin
      if (dn || m_wait == int'(TIMEOUT)) begin
        m_waiting = 1'b0; m_retiring = 1'b1; m_dsrc = m_src; m_derr = dn ? er : 1'b1;
      end else begin
        m_wait++;
      end
    end else if (m_offering) begin
      if (rdy) begin m_offering = 1'b0; m_waiting = 1'b1; m_wait = 0; end
    end else if (keep != 0) begin
      for (int k = 0; k < 6; k++) begin
        int i = (m_ptr + k) % 6;
        if (keep[i]) begin
          m_src = i; m_data = m_slot[i]; keep[i] = 1'b0; m_ptr = (i + 1) % 6; m_offering = 1'b1;
          break;
        end
      end
    end
    if (oc) m_ovr = '0;
    m_ovr = m_ovr | (a & keep);
    m_pend = keep | a;
    for (int i = 0; i < 6; i++) if (a[i]) m_slot[i] = j;
  endtask

  vec_t vecs [12];
  localparam logic [37:0] X = 38'h12_3456_789A;
  localparam logic [37:0] Y = 38'h3F_0000_0001;

  initial begin
    logic [5:0]  ra;
    logic [37:0] rj;
    logic        rr, rd, re, ro;
    int          n;

    //               act       jdo  rdy dn er oc  valid src data dp dsrc derr busy ovr
    vecs[0]  = mk(6'b000001, X,    0, 0, 0, 0,  0, 0, '0, 0, 0, 0, 1, '0);
    vecs[1]  = mk(6'b000000, '0,   0, 0, 0, 0,  1, 0, X,  0, 0, 0, 1, '0);
    vecs[2]  = mk(6'b000000, '0,   1, 0, 0, 0,  0, 0, X,  0, 0, 0, 1, '0);
    vecs[3]  = mk(6'b000000, '0,   0, 0, 0, 0,  0, 0, X,  0, 0, 0, 1, '0);
    vecs[4]  = mk(6'b000000, '0,   0, 0, 0, 0,  0, 0, X,  0, 0, 0, 1, '0);
    vecs[5]  = mk(6'b000000, '0,   0, 1, 0, 0,  0, 0, X,  1, 0, 0, 1, '0);
    vecs[6]  = mk(6'b000000, '0,   0, 0, 0, 0,  0, 0, X,  0, 0, 0, 0, '0);
    vecs[7]  = mk(6'b001000, Y,    0, 0, 0, 0,  0, 0, X,  0, 0, 0, 1, '0);
    vecs[8]  = mk(6'b000000, '0,   0, 0, 0, 0,  1, 3, Y,  0, 0, 0, 1, '0);
    vecs[9]  = mk(6'b000000, '0,   1, 1, 1, 0,  0, 3, Y,  0, 0, 0, 1, '0);
    vecs[10] = mk(6'b000000, '0,   0, 1, 1, 0,  0, 3, Y,  1, 3, 1, 1, '0);
    vecs[11] = mk(6'b000000, '0,   0, 0, 0, 0,  0, 3, Y,  0, 3, 1, 0, '0);

    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      bus.act_pulse = vecs[v].act; bus.jdo = vecs[v].jdo; bus.cmd_ready = vecs[v].rdy;
      bus.cmd_done = vecs[v].dn; bus.cmd_err = vecs[v].er; bus.ovr_clr = vecs[v].oc;
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), 64'(bus.cmd_valid), 64'(vecs[v].valid));
      chk($sformatf("v%0d_src", v),   64'(bus.cmd_src), 64'(vecs[v].src));
      chk($sformatf("v%0d_data", v),  64'(bus.cmd_data), 64'(vecs[v].data));
      chk($sformatf("v%0d_dp", v),    64'(bus.done_pulse), 64'(vecs[v].dp));
      chk($sformatf("v%0d_dsrc", v),  64'(bus.done_src), 64'(vecs[v].dsrc));
      chk($sformatf("v%0d_derr", v),  64'(bus.done_err), 64'(vecs[v].derr));
      chk($sformatf("v%0d_busy", v),  64'(bus.busy), 64'(vecs[v].busy));
      chk($sformatf("v%0d_ovr", v),   64'(bus.overrun), 64'(vecs[v].ovr));
    end
    drive_idle();

    // Round-robin: 0,2,5 together, then 0,5 with the pointer wrapped back to 0
    do_reset();
    bus.act_pulse = 6'b100101; bus.jdo = 38'h11;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10); chk("rr_first", 64'(bus.cmd_src), 0); finish_cmd(1'b0, 0);
    wait_valid(10); chk("rr_second", 64'(bus.cmd_src), 2); finish_cmd(1'b0, 2);
    wait_valid(10); chk("rr_third", 64'(bus.cmd_src), 5); finish_cmd(1'b0, 5);
    chk("rr_idle_busy", 64'(bus.busy), 0);
    bus.act_pulse = 6'b100001;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10); chk("rr_wrap_first", 64'(bus.cmd_src), 0); finish_cmd(1'b0, 0);
    wait_valid(10); chk("rr_wrap_second", 64'(bus.cmd_src), 5); finish_cmd(1'b0, 5);

    // Overrun, in-flight re-strobe and backpressure
    do_reset();
    bus.act_pulse = 6'b000010; bus.jdo = 38'h0D1;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10);
    chk("ovr_inflight_src", 64'(bus.cmd_src), 1);
    bus.act_pulse = 6'b001010; bus.jdo = 38'h0AA;
    @(negedge clk);
    bus.act_pulse = 6'b001000; bus.jdo = 38'h0BB;
    @(negedge clk);
    bus.act_pulse = '0; bus.jdo = '0;
    chk("ovr_set", 64'(bus.overrun), 64'(6'b001000));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.cmd_valid), 1);
      chk("bp_src", 64'(bus.cmd_src), 1);
      chk("bp_data", 64'(bus.cmd_data), 64'(38'h0D1));
      chk("bp_no_done", 64'(bus.done_pulse), 0);
    end
    finish_cmd(1'b1, 1);
    wait_valid(10);
    chk("ovr_issue_src", 64'(bus.cmd_src), 3);
    chk("ovr_issue_data", 64'(bus.cmd_data), 64'(38'h0BB));
    chk("ovr_sticky", 64'(bus.overrun), 64'(6'b001000));
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    chk("ovr_cleared", 64'(bus.overrun), 0);
    bus.act_pulse = 6'b000010; bus.jdo = 38'h0CC; bus.ovr_clr = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("ovr_wins_clr", 64'(bus.overrun), 64'(6'b000010));
    finish_cmd(1'b0, 3);
    wait_valid(10);
    chk("restrobe_src", 64'(bus.cmd_src), 1);
    chk("restrobe_data", 64'(bus.cmd_data), 64'(38'h0CC));
    finish_cmd(1'b0, 1);

    // Timeout with no completion, then completion on the final cycle
    bus.act_pulse = 6'b010000; bus.jdo = 38'h0EE;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    n = 0;
    while (!bus.done_pulse && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 64'(n), 64'(TIMEOUT + 1));
    chk("to_err", 64'(bus.done_err), 1);
    chk("to_src", 64'(bus.done_src), 4);
    @(negedge clk);
    bus.act_pulse = 6'b010000;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    chk("to_edge_nodone", 64'(bus.done_pulse), 0);
    bus.cmd_done = 1'b1; bus.cmd_err = 1'b0;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    chk("to_edge_pulse", 64'(bus.done_pulse), 1);
    chk("to_edge_err", 64'(bus.done_err), 0);
    @(negedge clk);

    // Reset while waiting, with src4 pending
    bus.act_pulse = 6'b000001; bus.jdo = 38'h0FF;
    @(negedge clk);
    bus.act_pulse = '0;
    wait_valid(10);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0; bus.act_pulse = 6'b010000;
    @(negedge clk);
    bus.act_pulse = '0;
    chk("rst_pre_busy", 64'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_wait");
    reset = 1'b0; bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    chk("rst_late_done", 64'(bus.done_pulse), 0);
    @(negedge clk);
    chk("rst_dropped_busy", 64'(bus.busy), 0);
    chk("rst_dropped_valid", 64'(bus.cmd_valid), 0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_valid", 64'(bus.cmd_valid), 64'(m_offering));
      chk("rnd_dp", 64'(bus.done_pulse), 64'(m_retiring));
      chk("rnd_busy", 64'(bus.busy), 64'(m_offering || m_waiting || m_retiring || (m_pend != 0)));
      chk("rnd_ovr", 64'(bus.overrun), 64'(m_ovr));
      chk("rnd_src", 64'(bus.cmd_src), 64'(m_src));
      chk("rnd_data", 64'(bus.cmd_data), 64'(m_data));
      chk("rnd_dsrc", 64'(bus.done_src), 64'(m_dsrc));
      chk("rnd_derr", 64'(bus.done_err), 64'(m_derr));
      ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'b0;
      rj = {6'($urandom), 32'($urandom)};
      rr = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 3) == 0);
      re = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 15) == 0);
      bus.act_pulse = ra; bus.jdo = rj; bus.cmd_ready = rr;
      bus.cmd_done = rd; bus.cmd_err = re; bus.ovr_clr = ro;
      model_step(ra, rj, rr, rd, re, ro);
      @(negedge clk);
    end
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
